// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester handshakes and ALU connection for the shared-ALU arbiter
interface alu_share_arbiter_if #(
  parameter int CPU_WIDTH     = 32,
  parameter int ALU_OPT_WIDTH = 4
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [CPU_WIDTH-1:0]     req0_in1;
  logic [CPU_WIDTH-1:0]     req0_in2;
  logic [ALU_OPT_WIDTH-1:0] req0_opt;
  logic                     resp0_valid;
  logic                     resp0_ready;
  logic [CPU_WIDTH-1:0]     resp0_res;
  logic                     req1_valid;
  logic                     req1_ready;
  logic [CPU_WIDTH-1:0]     req1_in1;
  logic [CPU_WIDTH-1:0]     req1_in2;
  logic [ALU_OPT_WIDTH-1:0] req1_opt;
  logic                     resp1_valid;
  logic                     resp1_ready;
  logic [CPU_WIDTH-1:0]     resp1_res;
  logic [CPU_WIDTH-1:0]     alu_in1;
  logic [CPU_WIDTH-1:0]     alu_in2;
  logic [ALU_OPT_WIDTH-1:0] alu_opt_code;
  logic [CPU_WIDTH-1:0]     alu_res;
  logic                     busy;
  modport master (
    output req0_valid, req0_in1, req0_in2, req0_opt, resp0_ready,
    output req1_valid, req1_in1, req1_in2, req1_opt, resp1_ready, alu_res,
    input  req0_ready, resp0_valid, resp0_res, req1_ready, resp1_valid, resp1_res,
    input  alu_in1, alu_in2, alu_opt_code, busy
  );
  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_opt, resp0_ready,
    input  req1_valid, req1_in1, req1_in2, req1_opt, resp1_ready, alu_res,
    output req0_ready, resp0_valid, resp0_res, req1_ready, resp1_valid, resp1_res,
    output alu_in1, alu_in2, alu_opt_code, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int CPU_WIDTH     = 32,
  parameter int ALU_OPT_WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                   state;
  logic                     prio;
  logic                     grant;
  logic [CPU_WIDTH-1:0]     in1_q;
  logic [CPU_WIDTH-1:0]     in2_q;
  logic [CPU_WIDTH-1:0]     res_q;
  logic [ALU_OPT_WIDTH-1:0] opt_q;
  logic                     take0;
  logic                     take1;
  logic                     done;
  // prio names the requester that wins a tie; a lone requester always wins
  always_comb begin
    take0 = state == IDLE && bus.req0_valid && (!bus.req1_valid || !prio);
    take1 = state == IDLE && bus.req1_valid && (!bus.req0_valid || prio);
    done  = state == RESP && (grant ? bus.resp1_ready : bus.resp0_ready);
  end
  assign bus.req0_ready   = take0;
  assign bus.req1_ready   = take1;
  assign bus.resp0_valid  = state == RESP && !grant;
  assign bus.resp1_valid  = state == RESP && grant;
  assign bus.resp0_res    = bus.resp0_valid ? res_q : '0;
  assign bus.resp1_res    = bus.resp1_valid ? res_q : '0;
  assign bus.busy         = state != IDLE;
  assign bus.alu_in1      = in1_q;
  assign bus.alu_in2      = in2_q;
  assign bus.alu_opt_code = opt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      grant <= 1'b0;
      in1_q <= '0;
      in2_q <= '0;
      opt_q <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (take0 || take1) begin
          grant <= take1;
          in1_q <= take1 ? bus.req1_in1 : bus.req0_in1;
          in2_q <= take1 ? bus.req1_in2 : bus.req0_in2;
          opt_q <= take1 ? bus.req1_opt : bus.req0_opt;
          state <= EXEC;
        end
        EXEC: begin
          res_q <= bus.alu_res;
          state <= RESP;
        end
        RESP: if (done) begin
          prio  <= !grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with per-requester result scoreboards
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  alu_share_arbiter_if #(.CPU_WIDTH(32), .ALU_OPT_WIDTH(4)) bus ();
  alu_share_arbiter #(.CPU_WIDTH(32), .ALU_OPT_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // reference ALU: opcode 0 adds, anything else subtracts
  always_comb bus.alu_res = bus.alu_opt_code == 4'd0 ? bus.alu_in1 + bus.alu_in2 : bus.alu_in1 - bus.alu_in2;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.resp0_valid && bus.resp0_ready) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp0_unexpected: got %h expected no response", bus.resp0_res);
      end else check("resp0_res", bus.resp0_res, q0.pop_front());
    end
    if (bus.resp1_valid && bus.resp1_ready) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp1_unexpected: got %h expected no response", bus.resp1_res);
      end else check("resp1_res", bus.resp1_res, q1.pop_front());
    end
    if (bus.resp1_valid) check("resp0_quiet", 32'(bus.resp0_valid) | bus.resp0_res, 32'd0);
    if (bus.resp0_valid) check("resp1_quiet", 32'(bus.resp1_valid) | bus.resp1_res, 32'd0);
  end
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, output int acc);
    bit ok = 1'b0;
    acc = -1;
    if (n == 0) begin
      bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_opt = op; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_opt = op; bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = n == 0 ? bus.req0_ready : bus.req1_ready;
      acc = cyc;
      @(posedge clk);
      #1;
    end
    if (n == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: requester %0d got no ready, required ready within 50 cycles", n);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d/%0d responses outstanding, required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end
  initial begin
    int a0, a1, c0;
    bus.req0_valid = 0; bus.req0_in1 = 0; bus.req0_in2 = 0; bus.req0_opt = 0; bus.resp0_ready = 1;
    bus.req1_valid = 0; bus.req1_in1 = 0; bus.req1_in2 = 0; bus.req1_opt = 0; bus.resp1_ready = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    check("rst_valid_busy", {29'd0, bus.resp0_valid, bus.resp1_valid, bus.busy}, 32'd0);
    check("rst_alu_in1", bus.alu_in1, 32'd0);
    check("rst_alu_in2", bus.alu_in2, 32'd0);
    check("rst_alu_opt", 32'(bus.alu_opt_code), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // single op on requester 1
    q1.push_back(32'd12);
    c0 = cyc;
    issue(1, 32'd5, 32'd7, 4'd0, a1);
    check("single_accept_at_T", 32'(a1), 32'(c0));
    @(negedge clk);
    check("single_busy_T1", 32'(bus.busy), 32'd1);
    check("single_novalid_T1", 32'(bus.resp1_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_valid_T2", 32'(bus.resp1_valid), 32'd1);
    check("single_busy_T2", 32'(bus.busy), 32'd1);
    drain();
    // contention from reset, then a second tie
    do_reset();
    q0.push_back(32'd3);
    q1.push_back(32'd30);
    fork
      issue(0, 32'd1, 32'd2, 4'd0, a0);
      issue(1, 32'd10, 32'd20, 4'd0, a1);
    join
    check("tie1_order", 32'(a1 - a0), 32'd3);
    drain();
    q0.push_back(32'd9);
    q1.push_back(32'd12);
    fork
      issue(0, 32'd4, 32'd5, 4'd0, a0);
      issue(1, 32'd6, 32'd6, 4'd0, a1);
    join
    check("tie2_order", 32'(a1 - a0), 32'd3);
    drain();
    // backpressure on requester 0 while requester 1 waits
    bus.resp0_ready = 1'b0;
    q0.push_back(32'd101);
    q1.push_back(32'd202);
    bus.req1_in1 = 32'd200; bus.req1_in2 = 32'd2; bus.req1_opt = 4'd0; bus.req1_valid = 1'b1;
    issue(0, 32'd100, 32'd1, 4'd0, a0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(bus.resp0_valid), 32'd1);
      check("bp_res_held", bus.resp0_res, 32'd101);
      check("bp_req1_blocked", 32'(bus.req1_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    check("bp_req1_blocked_release", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_req1_accept_after", 32'(bus.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    drain();
    // wraparound and subtraction pass-through
    q1.push_back(32'h0000_0000);
    issue(1, 32'hFFFF_FFFF, 32'd1, 4'd0, a1);
    drain();
    q0.push_back(32'hFFFF_FFFE);
    issue(0, 32'd5, 32'd7, 4'd1, a0);
    drain();
    // reset while requester 1 is in EXEC; prio had moved to requester 1
    issue(1, 32'd3, 32'd4, 4'd0, a1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_valid", {30'd0, bus.resp1_valid, bus.busy}, 32'd0);
    end
    check("midrst_alu_in1", bus.alu_in1, 32'd0);
    @(posedge clk);
    #1;
    q0.push_back(32'd15);
    q1.push_back(32'd7);
    fork
      issue(0, 32'd7, 32'd8, 4'd0, a0);
      issue(1, 32'd3, 32'd4, 4'd0, a1);
    join
    check("midrst_prio_req0", 32'(a1 - a0), 32'd3);
    drain();
    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
